// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: FSM states, queued command
// layout, response error codes and small helpers.
// Optional feature macro: I2C_CMD_SEQ_RETRY_EN (adds the BACKOFF state).
package i2c_pkg;

  // Widest payload a queued command can carry, in bytes.
  localparam int CMD_DATA_BYTES = 8;

  localparam logic [3:0] ERR_NONE   = 4'h0;
  localparam logic [3:0] ERR_BADLEN = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
`ifdef I2C_CMD_SEQ_RETRY_EN
    ST_BACKOFF = 3'd4,
`endif
    ST_REPORT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0]                  addr;
    logic [CMD_DATA_BYTES*8-1:0] data;
    logic [7:0]                  len;
  } cmd_t;

  // A length is usable when it names at least one byte and fits the payload.
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
    if (len == 8'd0) begin
      return 1'b0;
    end else if (len > max_len) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  // Reported retry count saturates at the width of rsp_tries.
  function automatic logic [1:0] sat_tries(input logic [7:0] n);
    if (n > 8'd3) begin
      return 2'd3;
    end else begin
      return n[1:0];
    end
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Command queue for the I2C sequencer: power-of-two depth, wrapping
// pointers, full/empty flags and a registered read port that updates on pop.
module i2c_cmd_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      rd_data  <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        rd_data  <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_seq.sv
// I2C command sequencer: queues commands, issues them one at a time to an
// I2C master, optionally retries failed transfers after a fixed back-off,
// and returns one response per command.
// Optional feature macro: I2C_CMD_SEQ_RETRY_EN (retry/back-off path).
module i2c_cmd_seq
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 3,
  parameter int BACKOFF    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_addr,
  input  logic [DATA_WIDTH*8-1:0] cmd_data,
  input  logic [7:0]              cmd_len,
  output logic                    start_i2c,
  output logic [7:0]              addr,
  output logic [DATA_WIDTH*8-1:0] data_in,
  output logic [7:0]              data_length,
  input  logic                    i2c_done,
  input  logic [3:0]              i2c_error,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_error,
  output logic [1:0]              rsp_tries
);

  localparam int            CMD_W     = $bits(cmd_t);
  localparam logic [7:0]    MAX_LEN_C = 8'(DATA_WIDTH);

  // Parameter sets outside these limits would silently misbehave.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_WIDTH < 1 ||
      DATA_WIDTH > CMD_DATA_BYTES || MAX_RETRY < 0 || MAX_RETRY > 255 || BACKOFF < 1) begin : g_bad_cfg
    $error("i2c_cmd_seq: unsupported parameter set");
  end

  state_t           state_r;
  cmd_t             wr_cmd_s;
  cmd_t             head_s;
  logic [CMD_W-1:0] fifo_rd_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_pop_s;

`ifdef I2C_CMD_SEQ_RETRY_EN
  localparam int         BW            = $clog2(BACKOFF + 1);
  localparam logic [BW-1:0] BO_LAST_C  = BW'(BACKOFF - 1);
  localparam logic [BW-1:0] BO_ONE_C   = BW'(1);
  localparam logic [7:0] RETRY_LIMIT_C = 8'(MAX_RETRY);

  logic [7:0]    retry_cnt_r;
  logic [BW-1:0] backoff_cnt_r;
  logic [1:0]    rsp_tries_r;

  assign rsp_tries = rsp_tries_r;
`else
  assign rsp_tries = 2'b00;
`endif

  assign cmd_ready  = ~fifo_full_s;
  assign fifo_pop_s = (state_r == ST_IDLE) & ~fifo_empty_s;
  assign head_s     = cmd_t'(fifo_rd_s);

  // Pack the incoming command; unused high payload bytes stay zero.
  always_comb begin
    wr_cmd_s = '0;
    wr_cmd_s.addr = cmd_addr;
    wr_cmd_s.data[DATA_WIDTH*8-1:0] = cmd_data;
    wr_cmd_s.len = cmd_len;
  end

  i2c_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid & cmd_ready),
    .pop     (fifo_pop_s),
    .wr_data (wr_cmd_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Sequencer FSM: one transfer in flight, registered master and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      start_i2c   <= 1'b0;
      addr        <= 8'h00;
      data_in     <= {(DATA_WIDTH*8){1'b0}};
      data_length <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_error   <= ERR_NONE;
`ifdef I2C_CMD_SEQ_RETRY_EN
      rsp_tries_r   <= 2'b00;
      retry_cnt_r   <= 8'h00;
      backoff_cnt_r <= {BW{1'b0}};
`endif
    end else begin
      start_i2c <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Master-facing fields hold from here until the response is taken.
          addr        <= head_s.addr;
          data_in     <= head_s.data[DATA_WIDTH*8-1:0];
          data_length <= head_s.len;
`ifdef I2C_CMD_SEQ_RETRY_EN
          retry_cnt_r <= 8'h00;
`endif
          if (len_ok(head_s.len, MAX_LEN_C)) begin
            state_r   <= ST_START;
            start_i2c <= 1'b1;
          end else begin
            state_r   <= ST_REPORT;
            rsp_valid <= 1'b1;
            rsp_error <= ERR_BADLEN;
`ifdef I2C_CMD_SEQ_RETRY_EN
            rsp_tries_r <= 2'b00;
`endif
          end
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!i2c_done) begin
            state_r <= ST_WAIT;
          end else if (i2c_error == ERR_NONE) begin
            state_r   <= ST_REPORT;
            rsp_valid <= 1'b1;
            rsp_error <= ERR_NONE;
`ifdef I2C_CMD_SEQ_RETRY_EN
            rsp_tries_r <= sat_tries(retry_cnt_r);
          end else if (retry_cnt_r < RETRY_LIMIT_C) begin
            state_r       <= ST_BACKOFF;
            backoff_cnt_r <= {BW{1'b0}};
`endif
          end else begin
            state_r   <= ST_REPORT;
            rsp_valid <= 1'b1;
            rsp_error <= i2c_error;
`ifdef I2C_CMD_SEQ_RETRY_EN
            rsp_tries_r <= sat_tries(retry_cnt_r);
`endif
          end
        end
`ifdef I2C_CMD_SEQ_RETRY_EN
        ST_BACKOFF: begin
          if (backoff_cnt_r == BO_LAST_C) begin
            state_r     <= ST_START;
            start_i2c   <= 1'b1;
            retry_cnt_r <= retry_cnt_r + 8'd1;
          end else begin
            state_r       <= ST_BACKOFF;
            backoff_cnt_r <= backoff_cnt_r + BO_ONE_C;
          end
        end
`endif
        ST_REPORT: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
          end else begin
            state_r <= ST_REPORT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: directed scenarios plus randomized
// command streams, checked against a per-command outcome model and an
// emulated I2C master that fails a scripted number of attempts.
module tb_i2c_cmd_seq;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int MR = 3;
  localparam int BO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_addr;
  logic [DW*8-1:0] cmd_data;
  logic [7:0]      cmd_len;
  logic            start_i2c;
  logic [7:0]      addr;
  logic [DW*8-1:0] data_in;
  logic [7:0]      data_length;
  logic            i2c_done;
  logic [3:0]      i2c_error;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [3:0]      rsp_error;
  logic [1:0]      rsp_tries;

  i2c_cmd_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_RETRY(MR), .BACKOFF(BO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_len(cmd_len),
    .start_i2c(start_i2c), .addr(addr), .data_in(data_in), .data_length(data_length),
    .i2c_done(i2c_done), .i2c_error(i2c_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error), .rsp_tries(rsp_tries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [63:0] d;
    logic [7:0]  l;
    int          fails;   // attempts the emulated master rejects before accepting
    logic [3:0]  e;       // error code returned on a rejected attempt
  } tcmd_t;

  tcmd_t send_q[$];
  tcmd_t exp_q[$];
  int    st_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         att = 0;
  bit         done_pend = 0;
  int         done_wait = 0;
  logic [3:0] done_err = 4'h0;
  int         done_delay_max = 0;
  bit         mute = 0;
  int         start_cnt = 0;
  bit         prev_start = 0;
  int         last_push_cyc = -1;
  int         first_start_cyc = -1;
  bit         rsp_hold = 0;
  int         ready_pct = 100;
  int         push_pct = 100;
  bit         held_valid = 0;
  logic [3:0] held_err;
  logic [1:0] held_tries;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bad_len(tcmd_t c);
    return (c.l == 8'd0) || (c.l > 8'(DW));
  endfunction

  // Number of start pulses the command should produce.
  function automatic int exp_attempts(tcmd_t c);
    if (bad_len(c)) return 0;
`ifdef I2C_CMD_SEQ_RETRY_EN
    return ((c.fails > MR) ? MR : c.fails) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [3:0] exp_err(tcmd_t c);
    if (bad_len(c)) return 4'hF;
`ifdef I2C_CMD_SEQ_RETRY_EN
    return (c.fails > MR) ? c.e : 4'h0;
`else
    return (c.fails > 0) ? c.e : 4'h0;
`endif
  endfunction

  function automatic logic [1:0] exp_tries(tcmd_t c);
    int n;
    if (bad_len(c)) return 2'd0;
`ifdef I2C_CMD_SEQ_RETRY_EN
    n = (c.fails > MR) ? MR : c.fails;
    return (n > 3) ? 2'd3 : 2'(n);
`else
    return 2'd0;
`endif
  endfunction

  function automatic tcmd_t mk(logic [7:0] a, logic [7:0] l, int f, logic [3:0] e);
    tcmd_t c;
    c.a = a; c.d = {$urandom, $urandom}; c.l = l; c.fails = f; c.e = e;
    return c;
  endfunction

  // One clock: observe outputs #1 after the edge, then set inputs for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    // emulated master: deliver a scheduled completion
    i2c_done  = 1'b0;
    i2c_error = 4'h0;
    if (done_pend) begin
      if (done_wait == 0) begin
        i2c_done  = 1'b1;
        i2c_error = done_err;
        done_pend = 0;
      end else begin
        done_wait--;
      end
    end
    if (start_i2c) begin
      check_val("start_width", 64'(prev_start), 64'd0);
      check_val("start_has_cmd", 64'(exp_q.size() > 0), 64'd1);
      start_cnt++;
      st_q.push_back(cyc);
      if (first_start_cyc < 0) first_start_cyc = cyc;
      if (exp_q.size() > 0) begin
        check_val("start_addr", 64'(addr), 64'(exp_q[0].a));
        check_val("start_data", 64'(data_in), exp_q[0].d);
        check_val("start_len", 64'(data_length), 64'(exp_q[0].l));
        att++;
        if (!mute) begin
          done_err  = (att <= exp_q[0].fails) ? exp_q[0].e : 4'h0;
          done_pend = 1;
          done_wait = $urandom_range(0, done_delay_max);
        end
      end
    end
    prev_start = start_i2c;
    // response consumer
    rsp_ready = 1'b0;
    if (rsp_valid) begin
      check_val("rsp_has_cmd", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        if (held_valid) begin
          check_val("rsp_err_stable", 64'(rsp_error), 64'(held_err));
          check_val("rsp_tries_stable", 64'(rsp_tries), 64'(held_tries));
        end
        check_val("rsp_addr_hold", 64'(addr), 64'(exp_q[0].a));
        check_val("rsp_len_hold", 64'(data_length), 64'(exp_q[0].l));
        if (!rsp_hold && $urandom_range(0, 99) < ready_pct) begin
          rsp_ready = 1'b1;
          check_val("rsp_error", 64'(rsp_error), 64'(exp_err(exp_q[0])));
          check_val("rsp_tries", 64'(rsp_tries), 64'(exp_tries(exp_q[0])));
          check_val("attempts", 64'(att), 64'(exp_attempts(exp_q[0])));
          void'(exp_q.pop_front());
          att = 0;
          held_valid = 0;
        end else begin
          held_err   = rsp_error;
          held_tries = rsp_tries;
          held_valid = 1;
        end
      end
    end else begin
      held_valid = 0;
    end
    // command producer
    cmd_valid = 1'b0;
    if (send_q.size() > 0 && $urandom_range(0, 99) < push_pct) begin
      cmd_valid = 1'b1;
      cmd_addr  = send_q[0].a;
      cmd_data  = send_q[0].d;
      cmd_len   = send_q[0].l;
      if (cmd_ready) begin
        exp_q.push_back(send_q.pop_front());
        last_push_cyc = cyc;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_val("drain_done", 64'(send_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_start"}, 64'(start_i2c), 64'd0);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    check_val({tag, "_rsp_tries"}, 64'(rsp_tries), 64'd0);
    check_val({tag, "_addr"}, 64'(addr), 64'd0);
    check_val({tag, "_data_in"}, 64'(data_in), 64'd0);
    check_val({tag, "_data_length"}, 64'(data_length), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_data = '0; cmd_len = 8'h00;
    i2c_done = 1'b0; i2c_error = 4'h0; rsp_ready = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    // single good command: start three cycles after the push, clean response
    first_start_cyc = -1; start_cnt = 0;
    send_q.push_back(mk(8'hAA, 8'd4, 0, 4'h0));
    drain(200);
    check_val("latency", 64'(first_start_cyc - last_push_cyc), 64'd3);
    check_val("single_starts", 64'(start_cnt), 64'd1);

    // zero length never reaches the master
    start_cnt = 0;
    send_q.push_back(mk(8'h51, 8'd0, 0, 4'h0));
    drain(200);
    check_val("len0_starts", 64'(start_cnt), 64'd0);
    start_cnt = 0;
    send_q.push_back(mk(8'h52, 8'(DW + 1), 0, 4'h0));
    drain(200);
    check_val("len_over_starts", 64'(start_cnt), 64'd0);

    // every attempt fails with error 2
    st_q.delete();
    send_q.push_back(mk(8'h60, 8'd3, 1000, 4'h2));
    drain(1000);
`ifdef I2C_CMD_SEQ_RETRY_EN
    check_val("retry_pulses", 64'(st_q.size()), 64'(MR + 1));
`else
    check_val("retry_pulses", 64'(st_q.size()), 64'd1);
`endif
    for (int i = 1; i < st_q.size(); i++) begin
      check_val("retry_spacing", 64'(st_q[i] - st_q[i-1]), 64'(BO + 2));
    end

    // fill the queue behind a stalled response, then hold the response
    rsp_hold = 1;
    for (int i = 0; i < 6; i++) send_q.push_back(mk(8'(8'h10 + i), 8'(1 + i % DW), 0, 4'h0));
    for (int i = 0; i < 8; i++) step();
    check_val("full_accepted", 64'(exp_q.size()), 64'd5);
    check_val("full_cmd_ready", 64'(cmd_ready), 64'd0);
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) step();
    check_val("hold_no_start", 64'(start_cnt), 64'(s0));
    check_val("hold_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_hold = 0;
    drain(2000);

    // randomized stream with back-pressure, failures and master delay
    push_pct = 60; ready_pct = 60; done_delay_max = 5;
    for (int i = 0; i < 30; i++) begin
      send_q.push_back(mk(8'($urandom), 8'($urandom_range(0, DW + 2)),
                          int'($urandom_range(0, 5)), 4'($urandom_range(1, 14))));
    end
    drain(20000);
    push_pct = 100; ready_pct = 100; done_delay_max = 0;

    // reset while a transfer is outstanding, with a second command queued
    mute = 1;
    s0 = start_cnt;
    send_q.push_back(mk(8'h77, 8'd2, 0, 4'h0));
    send_q.push_back(mk(8'h78, 8'd2, 0, 4'h0));
    n = 0;
    while (start_cnt == s0 && n < 20) begin step(); n++; end
    check_val("wait_start_seen", 64'(start_cnt > s0), 64'd1);
    step();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait");
    check_val("midwait_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete(); send_q.delete();
    att = 0; done_pend = 0; held_valid = 0; prev_start = 0; mute = 0;
    cmd_valid = 1'b0; rsp_ready = 1'b0; i2c_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // late completion from the abandoned transfer
    done_pend = 1; done_wait = 0; done_err = 4'h0;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) step();
    check_val("late_done_no_start", 64'(start_cnt), 64'(s0));
    check_val("late_done_no_rsp", 64'(rsp_valid), 64'd0);

    // sequencer still serves commands afterwards
    send_q.push_back(mk(8'h99, 8'd8, 1, 4'h5));
    drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_seq.md
I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the maximum payload bytes per command (byte 0 is the register address).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the command queue depth (power of two, at least 2).
REQ-003 SHALL have parameter MAX_RETRY, default 3, giving the re-issue attempts after a failed transfer.
REQ-004 SHALL have parameter BACKOFF, default 16, giving the idle cycles between a failed attempt and its retry.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command push handshake.
REQ-008 SHALL have ports cmd_addr (input, 8), cmd_data (input, DATA_WIDTH*8) and cmd_len (input, 8): slave address including R/W bit, payload with byte 0 in the MSBs, and byte count.
REQ-009 SHALL have ports start_i2c (output, 1), addr (output, 8), data_in (output, DATA_WIDTH*8) and data_length (output, 8): drive to the master.
REQ-010 SHALL have ports i2c_done (input, 1) and i2c_error (input, 4): a one-cycle transfer-complete pulse and the master error code (non-zero means failure).
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_error (output, 4) and rsp_tries (output, 2): per-command result handshake.

Function
REQ-012 cmd_ready SHALL equal "FIFO not full"; a push SHALL occur on any cycle where cmd_valid and cmd_ready are both high.
REQ-013 The FSM SHALL have the states IDLE, LOAD, START, WAIT, BACKOFF and REPORT.
REQ-014 IDLE with a non-empty FIFO SHALL pop the head command and go to LOAD on the next edge.
REQ-015 LOAD SHALL register addr, data_in and data_length from the popped command; if cmd_len is 0 or greater than DATA_WIDTH, it SHALL set rsp_error=4'hF and go to REPORT without issuing a transfer; otherwise it SHALL go to START.
REQ-016 START SHALL assert start_i2c for exactly one cycle and then go to WAIT; start_i2c SHALL be low in all other states.
REQ-017 WAIT SHALL hold until i2c_done: with i2c_error==0 go to REPORT; with i2c_error!=0 and tries<MAX_RETRY go to BACKOFF; otherwise go to REPORT carrying i2c_error.
REQ-018 BACKOFF SHALL count exactly BACKOFF cycles, increment tries, and then go to START.
REQ-019 In REPORT, rsp_valid SHALL be high and rsp_error/rsp_tries stable until rsp_ready; on the rsp_ready cycle the FSM SHALL return to IDLE.
REQ-020 Latency from push into an empty FIFO with the FSM in IDLE to start_i2c SHALL be 3 cycles.
REQ-021 addr, data_in and data_length SHALL remain stable from LOAD until leaving REPORT.
REQ-022 A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 tries SHALL saturate at 3.

Reset
REQ-025 Reset assertion SHALL asynchronously force IDLE, an empty FIFO, and start_i2c=0, rsp_valid=0, rsp_error=0, rsp_tries=0, addr=0, data_in=0 and data_length=0; cmd_ready SHALL be 1 after release.
REQ-026 Reset during WAIT SHALL abandon the command with no response, and a later i2c_done SHALL be ignored.

Configuration
REQ-027 With I2C_CMD_SEQ_RETRY_EN defined, the retry and BACKOFF path SHALL be present.
REQ-028 Without I2C_CMD_SEQ_RETRY_EN, WAIT SHALL always go to REPORT, the BACKOFF state and counter SHALL be absent, and rsp_tries SHALL be tied to 0.

Structure
REQ-029 Package i2c_pkg SHALL hold the FSM state enum, the command struct (addr, data, len) and the error constants ERR_NONE=4'h0 and ERR_BADLEN=4'hF.
REQ-030 The queue SHALL be a sub-module i2c_cmd_fifo with push/pop, full/empty and registered data.

Verification
REQ-031 Push addr=8'hAA, len=4, i2c_done with error 0 on the first try -> exactly one start_i2c pulse at cycle +3, then rsp_error=0 and rsp_tries=0.
REQ-032 Push len=0 -> no start_i2c, rsp_error=4'hF.
REQ-033 Drive i2c_error=4'h2 on every attempt -> 4 start pulses separated by BACKOFF+2 cycles, then rsp_error=2 and rsp_tries=3 (retry build); 1 pulse and rsp_tries=0 without the macro.
REQ-034 Push 5 commands back-to-back with FIFO_DEPTH=4 -> cmd_ready drops while full, and all commands complete in order.
REQ-035 Hold rsp_ready low for 10 cycles -> rsp fields stable and no new start_i2c.
REQ-036 Assert rst mid-WAIT -> all outputs reach reset values immediately, FIFO empty, and the late i2c_done is ignored.
